// File: rtl/mult_8x8_seq_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller.
// Holds the FSM state encoding, the step counter width, the combine-mode
// encodings and the per-step partial-product shift amounts.
package mult_8x8_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned STEP_W = 2;
    localparam logic [STEP_W-1:0] STEP_LAST = '1;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_OR  = 1'b1;

    localparam int unsigned SHIFT_S0 = 0;
    localparam int unsigned SHIFT_S1 = 4;
    localparam int unsigned SHIFT_S2 = 4;
    localparam int unsigned SHIFT_S3 = 8;

    function automatic int unsigned step_shift(input logic [STEP_W-1:0] step);
        case (step)
            2'd0:    return SHIFT_S0;
            2'd1:    return SHIFT_S1;
            2'd2:    return SHIFT_S2;
            default: return SHIFT_S3;
        endcase
    endfunction

    // Position an 8-bit partial product inside the 16-bit result for a step.
    function automatic logic [15:0] place_pp(input logic [7:0] pp,
                                             input logic [STEP_W-1:0] step);
        logic [15:0] wide;
        wide = {8'h00, pp};
        return wide << step_shift(step);
    endfunction

endpackage

// File: rtl/mul_4x4_exact.sv
// Combinational unsigned 4x4 multiplier shared by every step of the
// sequential 8x8 controller.
//   A : 4-bit multiplicand nibble
//   B : 4-bit multiplier nibble
//   R : 8-bit exact product
module mul_4x4_exact (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] R
);

    assign R = {4'h0, A} * {4'h0, B};

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller. One 4x4 multiplier is reused over
// four CALC cycles; each partial product is shifted into place and merged
// into a 16-bit accumulator by addition (exact) or bitwise OR (approximate).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// CALC  | one partial product merged per edge, steps 0..3
// DONE  | result held on R with out_valid high until out_ready
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B, mode)
//   A, B                : 8-bit operands
//   mode                : 0 = exact add, 1 = approximate OR
//   out_valid/out_ready : result handshake
//   R                   : 16-bit result (accumulator)
//   busy                : high whenever not IDLE
module mult_8x8_seq_ctrl
    import mult_8x8_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] R,
    output logic        busy
);

    state_t            state_q;
    logic [STEP_W-1:0] step_q;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic              mode_q;
    logic [15:0]       acc_q;
    logic [15:0]       acc_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [7:0]        pp;
    logic [15:0]       pp_placed;

    // Step 0: lo*lo, 1: lo(A)*hi(B), 2: hi(A)*lo(B), 3: hi*hi.
    assign a_nib = step_q[1] ? a_q[7:4] : a_q[3:0];
    assign b_nib = step_q[0] ? b_q[7:4] : b_q[3:0];

    mul_4x4_exact u_mul (
        .A (a_nib),
        .B (b_nib),
        .R (pp)
    );

    always_comb begin
        pp_placed = place_pp(pp, step_q);
        if (mode_q == MODE_OR) begin
            acc_d = acc_q | pp_placed;
        end else begin
            acc_d = acc_q + pp_placed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_ADD;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        b_q        <= B;
                        mode_q     <= mode;
                        acc_q      <= '0;
                        step_q     <= '0;
                        state_q    <= ST_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    step_q      <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign R         = acc_q;

endmodule

// File: doc/mult_8x8_seq_ctrl.md
MULT_8X8_SEQ_CTRL -- requirements
Module: mult_8x8_seq_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits, partial-product width at 8 bits, result width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair and mode on A/B/mode are valid.
REQ-005 in_ready  output  1  controller can accept a new operation.
REQ-006 A  input  8  multiplicand.
REQ-007 B  input  8  multiplier.
REQ-008 mode  input  1  combine mode: 0 = exact add, 1 = approximate OR.
REQ-009 out_valid  output  1  R holds a completed result.
REQ-010 out_ready  input  1  consumer accepts R.
REQ-011 R  output  16  product result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL time-multiplex one shared 4x4 multiplier over four steps to form an 8x8 product.
REQ-014 States SHALL be IDLE, CALC and DONE; a 2-bit step counter SHALL be used in CALC.
REQ-015 in_ready SHALL be 1 only in IDLE; an accept occurs on an edge with in_valid=1 and in_ready=1.
REQ-016 On accept, A, B and mode SHALL be latched, the accumulator cleared, step set to 0, and state set to CALC.
REQ-017 Step order SHALL be: 0 = A[3:0]*B[3:0] (shift 0); 1 = A[3:0]*B[7:4] (shift 4); 2 = A[7:4]*B[3:0] (shift 4); 3 = A[7:4]*B[7:4] (shift 8).
REQ-018 Each CALC edge SHALL merge the shifted 8-bit partial product into the 16-bit accumulator: add when latched mode=0, bitwise OR when latched mode=1.
REQ-019 Exact-mode accumulation SHALL be 16 bits wide; no overflow is possible, and no carry beyond bit 15 is kept.
REQ-020 On the step-3 edge, state SHALL go to DONE and out_valid SHALL rise.
REQ-021 Latency SHALL be: out_valid high exactly 4 clock edges after the accept edge.
REQ-022 In DONE, R and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL return state to IDLE and drop out_valid.
REQ-023 Input changes on A, B or mode after accept SHALL NOT affect the in-flight result.
REQ-024 An in_valid held high during CALC or DONE SHALL NOT be accepted; acceptance occurs no earlier than the cycle after returning to IDLE, so the minimum initiation interval is 6 cycles.
REQ-025 R SHALL present the accumulator at all times; its value is meaningful only while out_valid=1.

Reset
REQ-026 rst=1 SHALL asynchronously force state to IDLE, step to 0, the accumulator and R to 0x0000, out_valid to 0 and busy to 0; in_ready SHALL be 1 while in IDLE.
REQ-027 Reset during CALC or DONE SHALL abandon the operation, and no out_valid pulse SHALL follow.
REQ-028 The first accept after reset deassertion SHALL be possible on the first rising edge with rst=0.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE, CALC, DONE), the step width, the mode encodings (MODE_ADD=0, MODE_OR=1) and the per-step shift constants (0, 4, 4, 8).
REQ-030 A single combinational sub-module, mul_4x4_exact (4-bit A, 4-bit B, 8-bit R), SHALL be instantiated exactly once and fed by step-selected operand nibbles.

Verification
REQ-031 Accept A=0x12, B=0x34, mode=0 -> out_valid 4 edges after accept, R=0x03A8.
REQ-032 Same operands with mode=1 -> R=0x0368 (0x0008 | 0x0060 | 0x0040 | 0x0300).
REQ-033 A=0xFF, B=0xFF -> mode=0 gives R=0xFE01; mode=1 gives R=0xEFF1.
REQ-034 Hold out_ready=0 for 10 cycles after out_valid -> R and out_valid stay stable, in_ready stays 0, and a new in_valid is ignored until after the out_ready=1 edge.
REQ-035 Assert rst during step 2 of CALC -> immediate IDLE, R=0x0000, out_valid never pulses; a following A=0x03, B=0x05, mode=0 gives R=0x000F.
REQ-036 Change A/B on every cycle during CALC after accepting A=0x80, B=0x02, mode=0 -> R=0x0100.
